// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer with per-channel holding registers.
// Routes by s or round-robin pointer; a channel is reloadable in the same cycle it is acked.
module demux4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       s,
  input  logic             rr,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ack,
  output logic [1:0]       rr_ptr,
  output logic [7:0]       xfer_count
);

  logic [3:0][WIDTH-1:0] y_q, y_d;
  logic [3:0]            y_valid_q, y_valid_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [7:0]            xfer_count_q, xfer_count_d;
  logic [1:0]            tgt;
  logic                  xfer;

  always_comb begin
    tgt          = rr ? rr_ptr_q : s;
    in_ready     = ~y_valid_q[tgt] | y_ack[tgt];
    xfer         = in_valid & in_ready;
    y_d          = y_q;
    rr_ptr_d     = rr_ptr_q;
    xfer_count_d = xfer_count_q;
    // Acks on empty channels are harmless: clearing an already-clear bit.
    y_valid_d    = y_valid_q & ~y_ack;
    if (xfer) begin
      y_d[tgt]       = d;
      y_valid_d[tgt] = 1'b1;
      xfer_count_d   = xfer_count_q + 8'd1;
      if (rr) rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q          <= '0;
      y_valid_q    <= '0;
      rr_ptr_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y_valid    = y_valid_q;
  assign rr_ptr     = rr_ptr_q;
  assign xfer_count = xfer_count_q;

endmodule
